// File: rtl/alu_mult_sequencer.sv
// Shift-add unsigned WIDTHxWIDTH multiplier sequencing the shared ALU.
// Ports: clk, reset(n); start/mcand/mplier in; busy/done/hi/lo out; alu_* ALU link.
module alu_mult_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SIG_W = 6,
   parameter logic [SIG_W-1:0] ADD_CODE = 6'b100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_req,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SIG_W-1:0] alu_signal,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               carry;

   assign alu_a      = prod_q[2*WIDTH-1:WIDTH];
   assign alu_b      = mcand_q;
   assign alu_signal = ADD_CODE;

   // The ALU has no carry-out; an unsigned sum wrapped iff it is below A.
   assign carry = (alu_result < alu_a);

   always_comb begin
      state_d = state_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               prod_d  = {{WIDTH{1'b0}}, mplier};
               mcand_d = mcand;
               count_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (prod_q[0]) begin
               prod_d = {carry, alu_result, prod_q[WIDTH-1:1]};
            end else begin
               prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
            end
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d      = DONE;
               {hi_d, lo_d} = prod_d;
            end
         end
         default: state_d = IDLE;
      endcase
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         prod_q  <= '0;
         mcand_q <= '0;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign alu_req = busy_q;
   assign done    = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule
